mmio_port: RTL and testbench
============================

MMIO_PORT -- requirements
Module: mmio_port

Interface
REQ-001 Parameter BASE_ADDR, default 64'h0000_0000_0000_0100, is the 32-byte-aligned base of the I/O window.
REQ-002 Parameter DEBOUNCE_CYCLES, default 16, is the number of stable cycles required to accept a switch change (legal range 1..65535).
REQ-003 clk  input  1  rising-edge clock shared with the processor datapath.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 Address  input  64  data-memory address (ALU result).
REQ-006 Datawr  input  64  store data (register file read port 2).
REQ-007 MemWr  input  1  store strobe.
REQ-008 MemRd  input  1  load strobe.
REQ-009 sch  input  8  raw, asynchronous board switches.
REQ-010 io_sel  output  1  high when Address falls in the I/O window; data-memory read mux selects DM_io.
REQ-011 DM_io  output  64  load data from the I/O window.
REQ-012 led  output  8  board LEDs.

Function
REQ-013 io_sel SHALL be 1 iff Address[63:5] == BASE_ADDR[63:5], independent of MemRd/MemWr.
REQ-014 Register map, offset Address[4:3]: 0 LED_REG (R/W), 1 SW_REG (RO), 2 EDGE_REG (R/W1C), 3 reserved; Address[2:0] SHALL be ignored.
REQ-015 DM_io SHALL be combinational, zero-extended from 8 bits, and 0 when MemRd=0, io_sel=0, or the offset is reserved.
REQ-016 A store with MemWr=1, io_sel=1 and offset 0 SHALL load Datawr[7:0] into LED_REG on the rising edge; upper bits are discarded.
REQ-017 led SHALL equal LED_REG.
REQ-018 Stores to SW_REG and to the reserved offset SHALL have no effect.
REQ-019 sch SHALL pass through a 2-flop synchronizer before any other use.
REQ-020 Debounce: if the synchronized value differs from candidate, candidate is loaded and cnt is cleared to 0; otherwise, if cnt==DEBOUNCE_CYCLES-1, SW_REG is loaded with candidate; otherwise cnt increments.
REQ-021 cnt SHALL saturate at DEBOUNCE_CYCLES-1 and SHALL NOT wrap.
REQ-022 After sch changes and then holds steady, SW_REG SHALL update on the (DEBOUNCE_CYCLES+3)th rising edge after the change.
REQ-023 Any toggle before that edge restarts the debounce count, and SW_REG retains its old value.
REQ-024 A load and a store in the same cycle SHALL return the pre-write register value on DM_io.

Reset
REQ-025 rst_n=0 SHALL asynchronously clear LED_REG, SW_REG, EDGE_REG, candidate, cnt and both synchronizer stages to 0.
REQ-026 During reset, led SHALL be 0 and DM_io SHALL be 0.
REQ-027 A reset mid-debounce SHALL discard the pending change.
REQ-028 A switch held high through reset release SHALL be accepted DEBOUNCE_CYCLES+3 edges after release and SHALL set its edge flag.

Configuration
REQ-029 With MMIO_EDGE_CAPTURE_EN defined, each bit of EDGE_REG SHALL set on the edge where the same SW_REG bit goes 0->1.
REQ-030 With MMIO_EDGE_CAPTURE_EN defined, a store to offset 2 SHALL clear the EDGE_REG bits where Datawr[7:0] is 1.
REQ-031 With MMIO_EDGE_CAPTURE_EN defined, a set and a clear of the same bit on the same edge SHALL leave that bit set.
REQ-032 Without MMIO_EDGE_CAPTURE_EN, EDGE_REG SHALL be absent, offset 2 SHALL read 0, and stores to offset 2 SHALL be ignored.

Verification
REQ-033 Reset release; store Address=0x100, Datawr=0xFFFF_FFFF_FFFF_FFA5 -> led=0xA5 from the next edge; load 0x100 -> DM_io=0x00000000000000A5.
REQ-034 DEBOUNCE_CYCLES=4; sch 0x00->0x81 held -> SW_REG reads 0x81 after the 7th edge and 0x00 at edge 6.
REQ-035 DEBOUNCE_CYCLES=4; sch bit0 toggles every 2 cycles for 20 cycles, then goes low -> SW_REG never changes.
REQ-036 MMIO_EDGE_CAPTURE_EN defined; SW_REG bit3 rises while a store of 0x08 to 0x110 lands on the same edge -> EDGE_REG=0x08; a second store of 0x08 -> EDGE_REG=0x00.
REQ-037 Load at 0x0F8 and at 0x120 -> io_sel=0, DM_io=0; load at 0x118 -> io_sel=1, DM_io=0.
REQ-038 rst_n pulsed low at debounce edge 5 of 7 -> led=0 and SW_REG=0 immediately, with no later spurious update unless sch stays high.

Source files
------------

// File: rtl/mmio_port.sv
// Memory-mapped LED/switch port: LED register, debounced switch register and
// optional switch rising-edge capture (enabled by defining MMIO_EDGE_CAPTURE_EN).
module mmio_port #(
  parameter logic [63:0] BASE_ADDR       = 64'h0000_0000_0000_0100,
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [63:0] Address,
  input  logic [63:0] Datawr,
  input  logic        MemWr,
  input  logic        MemRd,
  input  logic [7:0]  sch,
  output logic        io_sel,
  output logic [63:0] DM_io,
  output logic [7:0]  led
);

  localparam int unsigned CNT_W = 16;
  localparam int unsigned REG_W = 8;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  localparam logic [1:0] OFF_LED  = 2'd0;
  localparam logic [1:0] OFF_SW   = 2'd1;
  localparam logic [1:0] OFF_EDGE = 2'd2;

  logic [1:0]       offset;
  logic             wr_led;
  logic             sw_load;
  logic [REG_W-1:0] led_reg;
  logic [REG_W-1:0] sw_reg;
  logic [REG_W-1:0] sync1;
  logic [REG_W-1:0] sync2;
  logic [REG_W-1:0] candidate;
  logic [CNT_W-1:0] cnt;
  logic [REG_W-1:0] edge_val;
  logic [REG_W-1:0] rd_data;
  logic             unused_bits;

  assign offset      = Address[4:3];
  assign io_sel      = (Address[63:5] == BASE_ADDR[63:5]);
  assign wr_led      = MemWr && io_sel && (offset == OFF_LED);
  assign sw_load     = (sync2 == candidate) && (cnt == CNT_MAX);
  assign led         = led_reg;
  assign unused_bits = ^{Address[2:0], Datawr[63:8]};

  // Synchronizer, debounce counter and LED register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1     <= '0;
      sync2     <= '0;
      candidate <= '0;
      cnt       <= '0;
      sw_reg    <= '0;
      led_reg   <= '0;
    end else begin
      sync1 <= sch;
      sync2 <= sync1;
      if (sync2 != candidate) begin
        candidate <= sync2;
        cnt       <= '0;
      end else if (cnt == CNT_MAX) begin
        sw_reg <= candidate;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
      if (wr_led) begin
        led_reg <= Datawr[REG_W-1:0];
      end
    end
  end

`ifdef MMIO_EDGE_CAPTURE_EN
  logic             wr_edge;
  logic [REG_W-1:0] edge_reg;
  logic [REG_W-1:0] edge_set;
  logic [REG_W-1:0] edge_clr;

  assign wr_edge  = MemWr && io_sel && (offset == OFF_EDGE);
  assign edge_set = sw_load ? (candidate & ~sw_reg) : '0;
  assign edge_clr = wr_edge ? Datawr[REG_W-1:0] : '0;
  assign edge_val = edge_reg;

  // Set wins over a simultaneous write-one-to-clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      edge_reg <= '0;
    end else begin
      edge_reg <= (edge_reg & ~edge_clr) | edge_set;
    end
  end
`else
  assign edge_val = '0;
`endif

  // Load data mux; reads see the pre-write register contents
  always_comb begin
    rd_data = '0;
    if (MemRd && io_sel) begin
      case (offset)
        OFF_LED:  rd_data = led_reg;
        OFF_SW:   rd_data = sw_reg;
        OFF_EDGE: rd_data = edge_val;
        default:  rd_data = '0;
      endcase
    end
    DM_io = {56'd0, rd_data};
  end

endmodule

// File: tb/tb_mmio_port.sv
// Directed self-checking bench for mmio_port with DEBOUNCE_CYCLES=4.
module tb_mmio_port;

  logic        clk;
  logic        rst_n;
  logic [63:0] Address;
  logic [63:0] Datawr;
  logic        MemWr;
  logic        MemRd;
  logic [7:0]  sch;
  logic        io_sel;
  logic [63:0] DM_io;
  logic [7:0]  led;

  int total;
  int bad;

`ifdef MMIO_EDGE_CAPTURE_EN
  localparam bit EDGE_ON = 1'b1;
`else
  localparam bit EDGE_ON = 1'b0;
`endif

  mmio_port #(
    .BASE_ADDR       (64'h0000_0000_0000_0100),
    .DEBOUNCE_CYCLES (4)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .Address (Address),
    .Datawr  (Datawr),
    .MemWr   (MemWr),
    .MemRd   (MemRd),
    .sch     (sch),
    .io_sel  (io_sel),
    .DM_io   (DM_io),
    .led     (led)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic store(input logic [63:0] addr, input logic [63:0] data);
    Address = addr;
    Datawr  = data;
    MemRd   = 1'b0;
    MemWr   = 1'b1;
    tick();
    MemWr   = 1'b0;
  endtask

  task automatic load(input logic [63:0] addr, output logic [63:0] data);
    Address = addr;
    MemRd   = 1'b1;
    #1;
    data    = DM_io;
    MemRd   = 1'b0;
  endtask

  task automatic test_reset();
    logic [63:0] d;
    rst_n = 1'b0; Address = '0; Datawr = '0; MemWr = 1'b0; MemRd = 1'b0; sch = 8'h00;
    repeat (3) tick();
    total++;
    if (led !== 8'h00) begin bad++; $display("FAIL reset_led got=%h want=00", led); end
    load(64'h100, d);
    total++;
    if (d !== 64'h0) begin bad++; $display("FAIL reset_dm_led got=%h want=0", d); end
    load(64'h108, d);
    total++;
    if (d !== 64'h0) begin bad++; $display("FAIL reset_dm_sw got=%h want=0", d); end
    rst_n = 1'b1;
    repeat (8) tick();
  endtask

  task automatic test_led();
    logic [63:0] d;
    store(64'h100, 64'hFFFF_FFFF_FFFF_FFA5);
    total++;
    if (led !== 8'hA5) begin bad++; $display("FAIL led_store got=%h want=a5", led); end
    load(64'h100, d);
    total++;
    if (d !== 64'h0000_0000_0000_00A5) begin bad++; $display("FAIL led_load got=%h want=a5", d); end
    store(64'h108, 64'hFF);
    store(64'h118, 64'h11);
    total++;
    if (led !== 8'hA5) begin bad++; $display("FAIL led_ro_store got=%h want=a5", led); end
    load(64'h108, d);
    total++;
    if (d !== 64'h0) begin bad++; $display("FAIL sw_ro_store got=%h want=0", d); end
    store(64'h105, 64'h3C);
    total++;
    if (led !== 8'h3C) begin bad++; $display("FAIL led_low_bits got=%h want=3c", led); end
    // Same-cycle load and store must return the old value
    Address = 64'h100; Datawr = 64'h5A; MemWr = 1'b1; MemRd = 1'b1;
    #1;
    total++;
    if (DM_io !== 64'h3C) begin bad++; $display("FAIL rd_wr_same got=%h want=3c", DM_io); end
    tick();
    MemWr = 1'b0; MemRd = 1'b0;
    total++;
    if (led !== 8'h5A) begin bad++; $display("FAIL rd_wr_after got=%h want=5a", led); end
  endtask

  task automatic test_decode();
    logic [63:0] d;
    logic        s;
    Address = 64'h0F8; MemRd = 1'b1; #1; s = io_sel; d = DM_io;
    total++;
    if (s !== 1'b0 || d !== 64'h0) begin bad++; $display("FAIL dec_0f8 sel=%b dm=%h want sel=0 dm=0", s, d); end
    Address = 64'h120; #1; s = io_sel; d = DM_io;
    total++;
    if (s !== 1'b0 || d !== 64'h0) begin bad++; $display("FAIL dec_120 sel=%b dm=%h want sel=0 dm=0", s, d); end
    Address = 64'h118; #1; s = io_sel; d = DM_io;
    total++;
    if (s !== 1'b1 || d !== 64'h0) begin bad++; $display("FAIL dec_118 sel=%b dm=%h want sel=1 dm=0", s, d); end
    Address = 64'h100; MemRd = 1'b0; #1; s = io_sel; d = DM_io;
    total++;
    if (s !== 1'b1 || d !== 64'h0) begin bad++; $display("FAIL dec_nord sel=%b dm=%h want sel=1 dm=0", s, d); end
    Address = 64'h1000_0000_0000_0100; #1; s = io_sel;
    total++;
    if (s !== 1'b0) begin bad++; $display("FAIL dec_high sel=%b want=0", s); end
  endtask

  task automatic test_glitch();
    logic [63:0] d;
    int          errs;
    errs = 0;
    for (int i = 0; i < 20; i++) begin
      if (i % 2 == 0) sch[0] = ~sch[0];
      tick();
      load(64'h108, d);
      if (d !== 64'h0) errs++;
    end
    total++;
    if (errs != 0) begin bad++; $display("FAIL glitch_toggle cycles_changed=%0d want=0", errs); end
    sch = 8'h00;
    repeat (10) tick();
    load(64'h108, d);
    total++;
    if (d !== 64'h0) begin bad++; $display("FAIL glitch_settle got=%h want=0", d); end
  endtask

  task automatic test_debounce();
    logic [63:0] d;
    sch = 8'h81;
    repeat (6) tick();
    load(64'h108, d);
    total++;
    if (d !== 64'h0) begin bad++; $display("FAIL deb_edge6 got=%h want=0", d); end
    tick();
    load(64'h108, d);
    total++;
    if (d !== 64'h81) begin bad++; $display("FAIL deb_edge7 got=%h want=81", d); end
    load(64'h110, d);
    total++;
    if (d !== (EDGE_ON ? 64'h81 : 64'h0)) begin bad++; $display("FAIL deb_edge_flags got=%h want=%h", d, EDGE_ON ? 64'h81 : 64'h0); end
    store(64'h110, 64'hFF);
    load(64'h110, d);
    total++;
    if (d !== 64'h0) begin bad++; $display("FAIL edge_w1c_all got=%h want=0", d); end
  endtask

  task automatic test_reset_mid();
    logic [63:0] d;
    sch = 8'h00;
    repeat (10) tick();
    store(64'h100, 64'h77);
    sch = 8'h42;
    repeat (5) tick();
    rst_n = 1'b0;
    #1;
    total++;
    if (led !== 8'h00) begin bad++; $display("FAIL rstmid_led got=%h want=00", led); end
    load(64'h108, d);
    total++;
    if (d !== 64'h0) begin bad++; $display("FAIL rstmid_sw got=%h want=0", d); end
    sch = 8'h00;
    tick();
    rst_n = 1'b1;
    repeat (12) tick();
    load(64'h108, d);
    total++;
    if (d !== 64'h0) begin bad++; $display("FAIL rstmid_no_spurious got=%h want=0", d); end
    // Switch held high through reset release
    sch = 8'h42;
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    repeat (6) tick();
    load(64'h108, d);
    total++;
    if (d !== 64'h0) begin bad++; $display("FAIL rsthold_edge6 got=%h want=0", d); end
    tick();
    load(64'h108, d);
    total++;
    if (d !== 64'h42) begin bad++; $display("FAIL rsthold_edge7 got=%h want=42", d); end
    load(64'h110, d);
    total++;
    if (d !== (EDGE_ON ? 64'h42 : 64'h0)) begin bad++; $display("FAIL rsthold_flag got=%h want=%h", d, EDGE_ON ? 64'h42 : 64'h0); end
  endtask

  task automatic test_edge_capture();
    logic [63:0] d;
    store(64'h110, 64'hFF);
    sch = 8'h4A;
    repeat (6) tick();
    // Bit3 rises on the same edge as the clearing store
    store(64'h110, 64'h08);
    load(64'h108, d);
    total++;
    if (d !== 64'h4A) begin bad++; $display("FAIL edge_sw got=%h want=4a", d); end
    load(64'h110, d);
    total++;
    if (d !== (EDGE_ON ? 64'h08 : 64'h0)) begin bad++; $display("FAIL edge_set_wins got=%h want=%h", d, EDGE_ON ? 64'h08 : 64'h0); end
    store(64'h110, 64'h08);
    load(64'h110, d);
    total++;
    if (d !== 64'h0) begin bad++; $display("FAIL edge_clear got=%h want=0", d); end
    total++;
    if (led !== 8'h00) begin bad++; $display("FAIL edge_led_untouched got=%h want=00", led); end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_led();
    test_decode();
    test_glitch();
    test_debounce();
    test_reset_mid();
    test_edge_capture();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
